// File: rtl/bram_pkg.sv
// Shared definitions for the block-RAM port front ends: request kinds,
// read-latency derivation and a constant-friendly clog2.
package bram_pkg;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_kind_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // A pipelined RAM adds one output register stage.
  function automatic int read_latency(input int pipelined);
    return 1 + pipelined;
  endfunction

endpackage

// File: rtl/bram_resp_fifo.sv
// Circular response buffer with an explicit occupancy count; pointers wrap at
// DEPTH-1 so any depth works, not only powers of two.
module bram_resp_fifo
  import bram_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
  localparam int CW = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is deliberately left unreset; dout is only meaningful while count != 0.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/bram_port_server.sv
// Valid/ready front end for one block-RAM port: issues RAM accesses, follows
// the read latency with a tag pipe and parks returned data in a credited FIFO.
module bram_port_server
  import bram_pkg::*;
#(
  parameter int PIPELINED     = 0,
  parameter int ADDR_WIDTH    = 1,
  parameter int DATA_WIDTH    = 1,
  parameter int RESP_DEPTH    = 4,
  parameter int RESP_ON_WRITE = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_DATA,
  output logic                  RESP_VALID,
  input  logic                  RESP_READY,
  output logic [DATA_WIDTH-1:0] RESP_DATA,
  output logic                  RAM_EN,
  output logic                  RAM_WE,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_DI,
  input  logic [DATA_WIDTH-1:0] RAM_DO
);

  localparam int LAT = read_latency(PIPELINED);
  localparam int CW  = clog2(RESP_DEPTH + 1);

  // Handshake: a request transfers on a cycle where REQ_VALID && REQ_READY,
  // a response transfers on a cycle where RESP_VALID && RESP_READY; REQ_READY
  // is built from registered state, RST and (for non-responding writes) REQ_WRITE only.
  logic          fire;
  logic          rgr;
  logic          issue;
  logic          push;
  logic          pop;
  logic [CW-1:0] credits;
  logic [CW-1:0] fifo_count;
  logic [LAT-1:0] tags;

  assign rgr       = (req_kind_e'(REQ_WRITE) == REQ_RD) || (RESP_ON_WRITE != 0);
  assign REQ_READY = !RST && ((credits != '0) || ((RESP_ON_WRITE == 0) && REQ_WRITE));
  assign fire      = REQ_VALID && REQ_READY;
  assign issue     = fire && rgr;

  assign RAM_EN   = fire;
  assign RAM_WE   = fire && REQ_WRITE;
  assign RAM_ADDR = REQ_ADDR;
  assign RAM_DI   = REQ_DATA;

  // A credit is spent per response-generating request and returned per pop, so
  // the FIFO can never be pushed while full.
  always_ff @(posedge CLK) begin
    if (RST) credits <= CW'(RESP_DEPTH);
    else     credits <= credits - CW'(issue) + CW'(pop);
  end

  generate
    if (LAT == 1) begin : g_tag1
      always_ff @(posedge CLK) begin
        if (RST) tags <= '0;
        else     tags <= issue;
      end
    end else begin : g_tagn
      always_ff @(posedge CLK) begin
        if (RST) tags <= '0;
        else     tags <= {tags[LAT-2:0], issue};
      end
    end
  endgenerate

  // The oldest tag marks the cycle in which RAM_DO carries that request's data.
  assign push       = tags[LAT-1];
  assign RESP_VALID = !RST && (fifo_count != '0);
  assign pop        = RESP_VALID && RESP_READY;

  bram_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (RAM_DO),
    .dout  (RESP_DATA),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_bram_port_server.sv
// Bench for bram_port_server: two configurations, each driving its own
// write-first RAM model, checked every cycle against a transaction-level model.
module tb_bram_port_server;

  logic clk = 1'b0;
  logic ram_init;
  logic       rst [2];
  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_write [2];
  logic [3:0] req_addr [2];
  logic [7:0] req_data [2];
  logic       resp_valid [2];
  logic       resp_ready [2];
  logic [7:0] resp_data [2];
  logic       ram_en [2];
  logic       ram_we [2];
  logic [3:0] ram_addr [2];
  logic [7:0] ram_di [2];
  logic [7:0] ram_do [2];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] exp_q [2][$];
  int         acc_q [2][$];
  logic [7:0] shadow [2][16];
  int         obs_acc [2];
  int         obs_pop [2];
  logic [7:0] last_pop [2];
  int         first_vld [2];

  initial forever #5 clk = ~clk;

  bram_port_server #(.PIPELINED(0), .ADDR_WIDTH(4), .DATA_WIDTH(8),
                     .RESP_DEPTH(4), .RESP_ON_WRITE(0)) dut0 (
    .CLK(clk), .RST(rst[0]), .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]),
    .REQ_WRITE(req_write[0]), .REQ_ADDR(req_addr[0]), .REQ_DATA(req_data[0]),
    .RESP_VALID(resp_valid[0]), .RESP_READY(resp_ready[0]), .RESP_DATA(resp_data[0]),
    .RAM_EN(ram_en[0]), .RAM_WE(ram_we[0]), .RAM_ADDR(ram_addr[0]),
    .RAM_DI(ram_di[0]), .RAM_DO(ram_do[0]));

  bram_port_server #(.PIPELINED(1), .ADDR_WIDTH(4), .DATA_WIDTH(8),
                     .RESP_DEPTH(5), .RESP_ON_WRITE(1)) dut1 (
    .CLK(clk), .RST(rst[1]), .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]),
    .REQ_WRITE(req_write[1]), .REQ_ADDR(req_addr[1]), .REQ_DATA(req_data[1]),
    .RESP_VALID(resp_valid[1]), .RESP_READY(resp_ready[1]), .RESP_DATA(resp_data[1]),
    .RAM_EN(ram_en[1]), .RAM_WE(ram_we[1]), .RAM_ADDR(ram_addr[1]),
    .RAM_DI(ram_di[1]), .RAM_DO(ram_do[1]));

  // Write-first RAM port; instance 1 adds an output register stage.
  for (genvar g = 0; g < 2; g++) begin : g_ram
    logic [7:0] mem [16];
    logic [7:0] do1;
    logic [7:0] do2;
    always @(posedge clk) begin
      if (ram_init) begin
        for (int i = 0; i < 16; i++) mem[i] <= 8'(i * 3);
      end else if (ram_en[g]) begin
        if (ram_we[g]) begin
          mem[ram_addr[g]] <= ram_di[g];
          do1 <= ram_di[g];
        end else begin
          do1 <= mem[ram_addr[g]];
        end
      end
      do2 <= do1;
    end
    assign ram_do[g] = (g == 1) ? do2 : do1;
  end

  function automatic int dep(input int k);
    return (k == 0) ? 4 : 5;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic int row(input int k);
    return (k == 0) ? 0 : 1;
  endfunction

  function automatic logic push_when_full(input int k);
    if (k == 0) return dut0.push && (dut0.u_fifo.count == 3'd4);
    return dut1.push && (dut1.u_fifo.count == 3'd5);
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] cycle=%0d observed=%0h expected=%0h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic v, input logic w, input logic [3:0] a,
                       input logic [7:0] d);
    req_valid[k] = v;
    req_write[k] = w;
    req_addr[k]  = a;
    req_data[k]  = d;
  endtask

  // One clock: check both instances mid-cycle, then advance the model.
  task automatic step();
    logic exp_rdy, exp_fire, exp_vld;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      exp_rdy = !rst[k] && ((exp_q[k].size() < dep(k)) || (row(k) == 0 && req_write[k]));
      exp_fire = req_valid[k] && exp_rdy;
      exp_vld = 1'b0;
      if (!rst[k] && exp_q[k].size() != 0) exp_vld = (cyc >= acc_q[k][0] + lat(k) + 1);
      chk("req_ready", k, req_ready[k], exp_rdy);
      chk("ram_en", k, ram_en[k], exp_fire);
      chk("ram_we", k, ram_we[k], exp_fire && req_write[k]);
      if (exp_fire) begin
        chk("ram_addr", k, ram_addr[k], req_addr[k]);
        chk("ram_di", k, ram_di[k], req_data[k]);
      end
      chk("resp_valid", k, resp_valid[k], exp_vld);
      if (exp_vld) chk("resp_data", k, resp_data[k], exp_q[k][0]);
      chk("push_when_full", k, push_when_full(k), 1'b0);
      if (req_valid[k] === 1'b1 && req_ready[k] === 1'b1) obs_acc[k]++;
      if (resp_valid[k] === 1'b1 && resp_ready[k] === 1'b1) begin
        obs_pop[k]++;
        last_pop[k] = resp_data[k];
      end
      if (resp_valid[k] === 1'b1 && first_vld[k] < 0) first_vld[k] = cyc;
      if (rst[k]) begin
        exp_q[k].delete();
        acc_q[k].delete();
      end else begin
        if (exp_vld && resp_ready[k]) begin
          void'(exp_q[k].pop_front());
          void'(acc_q[k].pop_front());
        end
        if (exp_fire) begin
          if (req_write[k]) shadow[k][req_addr[k]] = req_data[k];
          if (!req_write[k] || row(k) == 1) begin
            exp_q[k].push_back(shadow[k][req_addr[k]]);
            acc_q[k].push_back(cyc);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int a0, p0, t0;
    ram_init = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      resp_ready[k] = 1'b0;
      drive(k, 1'b0, 1'b0, 4'd0, 8'd0);
      obs_acc[k] = 0;
      obs_pop[k] = 0;
      last_pop[k] = 8'd0;
      first_vld[k] = -1;
      for (int i = 0; i < 16; i++) shadow[k][i] = 8'(i * 3);
    end
    @(posedge clk);
    #1;
    steps(3);
    ram_init = 1'b0;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    steps(1);

    // Instance 0: 16 back-to-back reads with the consumer always ready.
    resp_ready[0] = 1'b1;
    a0 = obs_acc[0];
    p0 = obs_pop[0];
    for (int i = 0; i < 16; i++) begin
      drive(0, 1'b1, 1'b0, 4'(i), 8'd0);
      step();
    end
    drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
    steps(4);
    chk("stream_accepts", 0, obs_acc[0] - a0, 16);
    chk("stream_responses", 0, obs_pop[0] - p0, 16);
    chk("stream_last_data", 0, last_pop[0], 8'd45);

    // Instance 0: credit stall, then a single-cycle pop releases one request.
    resp_ready[0] = 1'b0;
    a0 = obs_acc[0];
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b1, 1'b0, 4'(i + 8), 8'd0);
      step();
    end
    chk("stall_accepts", 0, obs_acc[0] - a0, 4);
    resp_ready[0] = 1'b1;
    step();
    resp_ready[0] = 1'b0;
    steps(3);
    chk("stall_release_accepts", 0, obs_acc[0] - a0, 5);

    // Write with no credits left is still taken when writes do not respond.
    a0 = obs_acc[0];
    drive(0, 1'b1, 1'b1, 4'd2, 8'h3C);
    step();
    chk("write_no_credit_accepted", 0, obs_acc[0] - a0, 1);
    drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
    resp_ready[0] = 1'b1;
    steps(8);
    drive(0, 1'b1, 1'b0, 4'd2, 8'd0);
    step();
    drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
    steps(4);
    chk("readback_addr2", 0, last_pop[0], 8'h3C);

    // Instance 0 latency: response appears two cycles after the read.
    drive(0, 1'b1, 1'b1, 4'd5, 8'hA5);
    step();
    drive(0, 1'b1, 1'b0, 4'd5, 8'd0);
    first_vld[0] = -1;
    t0 = cyc;
    step();
    drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
    steps(6);
    chk("latency_p0", 0, first_vld[0] - t0, 2);
    chk("latency_p0_data", 0, last_pop[0], 8'hA5);

    // Instance 1 latency with the pipelined RAM (the write also responds).
    resp_ready[1] = 1'b1;
    drive(1, 1'b1, 1'b1, 4'd5, 8'hA5);
    step();
    drive(1, 1'b0, 1'b0, 4'd0, 8'd0);
    steps(6);
    drive(1, 1'b1, 1'b0, 4'd5, 8'd0);
    first_vld[1] = -1;
    t0 = cyc;
    step();
    drive(1, 1'b0, 1'b0, 4'd0, 8'd0);
    steps(6);
    chk("latency_p1", 1, first_vld[1] - t0, 3);
    chk("latency_p1_data", 1, last_pop[1], 8'hA5);

    // Instance 1: write then read of the same address, both respond with 0x11.
    p0 = obs_pop[1];
    drive(1, 1'b1, 1'b1, 4'd7, 8'h11);
    step();
    drive(1, 1'b1, 1'b0, 4'd7, 8'd0);
    step();
    drive(1, 1'b0, 1'b0, 4'd0, 8'd0);
    steps(6);
    chk("row_pair_count", 1, obs_pop[1] - p0, 2);
    chk("row_pair_last", 1, last_pop[1], 8'h11);

    // Instance 1: reset in the middle of three in-flight reads.
    resp_ready[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b1, 1'b0, 4'(i), 8'd0);
      step();
    end
    drive(1, 1'b0, 1'b0, 4'd0, 8'd0);
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    resp_ready[1] = 1'b1;
    p0 = obs_pop[1];
    steps(6);
    chk("reset_discards", 1, obs_pop[1] - p0, 0);
    resp_ready[1] = 1'b0;
    a0 = obs_acc[1];
    for (int i = 0; i < 8; i++) begin
      drive(1, 1'b1, 1'b0, 4'(i), 8'd0);
      step();
    end
    chk("reset_credits", 1, obs_acc[1] - a0, 5);
    drive(1, 1'b1, 1'b1, 4'd3, 8'h77);
    a0 = obs_acc[1];
    step();
    chk("responding_write_blocked", 1, obs_acc[1] - a0, 0);
    drive(1, 1'b0, 1'b0, 4'd0, 8'd0);
    resp_ready[1] = 1'b1;
    steps(8);

    // Randomized traffic on both instances with occasional resets.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        drive(k, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
        resp_ready[k] = $urandom_range(0, 3) != 0;
        rst[k] = $urandom_range(0, 99) == 0;
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      drive(k, 1'b0, 1'b0, 4'd0, 8'd0);
      resp_ready[k] = 1'b1;
      rst[k] = 1'b0;
    end
    steps(10);
    chk("drained0", 0, exp_q[0].size(), 0);
    chk("drained1", 1, exp_q[1].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
